// File: rtl/pod_mem_arbiter.sv
// Round-robin arbiter that shares the single pod-memory BRAM port among N_REQ requesters.
// It registers the winning command and routes tagged read responses back after the BRAM read latency.
module pod_mem_arbiter #(
    parameter int N_REQ  = 7,
    parameter int ADDR_W = 14,
    parameter int D_W    = 64,
    parameter int RD_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*D_W-1:0]    req_wdata,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [D_W-1:0]          mem_wdata,
    input  logic [D_W-1:0]          mem_rdata,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [D_W-1:0]          rsp_data,
    output logic [2:0]              grant_id
);

    localparam int ID_W = 3;

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W:0]     cand;
    logic              win_any;
    logic [ID_W-1:0]   win_id;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [D_W-1:0]    win_wdata;

    logic [RD_LAT:0]   tag_v;
    logic [ID_W-1:0]   tag_id [RD_LAT+1];
    logic [N_REQ-1:0]  tag_onehot;

    // Scan starts at rr_ptr and wraps at N_REQ; the first valid id wins.
    always_comb begin
        win_any = 1'b0;
        win_id  = '0;
        cand    = '0;
        if (ce && !rst) begin
            for (int unsigned o = 0; o < N_REQ; o++) begin
                cand = {1'b0, rr_ptr} + (ID_W+1)'(o);
                if (cand >= (ID_W+1)'(N_REQ))
                    cand = cand - (ID_W+1)'(N_REQ);
                if (!win_any && req_valid[cand[ID_W-1:0]]) begin
                    win_any = 1'b1;
                    win_id  = cand[ID_W-1:0];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (win_any)
            req_ready[win_id] = 1'b1;
        win_we    = req_we[win_id];
        win_addr  = req_addr[win_id*ADDR_W +: ADDR_W];
        win_wdata = req_wdata[win_id*D_W +: D_W];
    end

    always_comb begin
        tag_onehot = '0;
        tag_onehot[tag_id[RD_LAT]] = 1'b1;
    end

    // Tag pipe stage RD_LAT lines up with mem_rdata; the response is then registered once more.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            grant_id  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            tag_v     <= '0;
            for (int unsigned i = 0; i <= RD_LAT; i++)
                tag_id[i] <= '0;
        end else if (ce) begin
            if (win_any) begin
                rr_ptr    <= (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + 1'b1;
                mem_en    <= 1'b1;
                mem_we    <= win_we;
                mem_addr  <= win_addr;
                mem_wdata <= win_wdata;
                grant_id  <= win_id;
            end else begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end
            tag_v     <= {tag_v[RD_LAT-1:0], win_any & ~win_we};
            tag_id[0] <= win_id;
            for (int unsigned i = 1; i <= RD_LAT; i++)
                tag_id[i] <= tag_id[i-1];
            rsp_valid <= tag_v[RD_LAT] ? tag_onehot : '0;
            if (tag_v[RD_LAT])
                rsp_data <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_pod_mem_arbiter.sv
// Directed and randomized bench for pod_mem_arbiter with a WRITE_FIRST BRAM model.
// A transaction-level reference model predicts grants, the command register and read responses.
module tb_pod_mem_arbiter;

    localparam int N_REQ  = 7;
    localparam int ADDR_W = 14;
    localparam int D_W    = 64;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    ce;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_we;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*D_W-1:0]    req_wdata;
    logic [N_REQ-1:0]        req_ready;
    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [D_W-1:0]          mem_wdata;
    logic [D_W-1:0]          mem_rdata = '0;
    logic [N_REQ-1:0]        rsp_valid;
    logic [D_W-1:0]          rsp_data;
    logic [2:0]              grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pod_mem_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .D_W(D_W), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .grant_id(grant_id)
    );

    function automatic logic [D_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return {16'hC0DE, 2'b00, a, 16'h5A5A, 2'b00, a};
    endfunction

    // BRAM: WRITE_FIRST single port, output register, shares ce; 2-cycle read latency.
    bit [D_W-1:0] bram    [0:(1<<ADDR_W)-1];
    bit           bram_wr [0:(1<<ADDR_W)-1];
    logic [D_W-1:0] ram_q = '0;
    always @(posedge clk) begin
        if (ce) begin
            if (mem_en) begin
                if (mem_we) begin
                    bram[mem_addr]    <= mem_wdata;
                    bram_wr[mem_addr] <= 1'b1;
                    ram_q             <= mem_wdata;
                end else begin
                    ram_q <= bram_wr[mem_addr] ? bram[mem_addr] : init_val(mem_addr);
                end
            end
            mem_rdata <= ram_q;
        end
    end

    // Reference model: memory contents as of each grant, expected registered outputs.
    typedef struct {
        int             id;
        logic [D_W-1:0] data;
        int             age;
    } rsp_t;

    rsp_t             pend [$];
    logic [D_W-1:0]   ref_mem [int];
    int               ptr = 0;
    logic             e_en = 1'b0, e_we = 1'b0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [D_W-1:0]   e_wdata = '0, e_rdata = '0;
    logic [2:0]       e_gid = '0;
    logic [N_REQ-1:0] e_rsp = '0;
    int               last_g = -1;

    function automatic logic [D_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    function automatic int exp_grant();
        if (rst || !ce) return -1;
        for (int o = 0; o < N_REQ; o++)
            if (req_valid[(ptr + o) % N_REQ]) return (ptr + o) % N_REQ;
        return -1;
    endfunction

    task automatic model_edge(input int g);
        rsp_t r;
        logic [ADDR_W-1:0] a;
        if (rst) begin
            ptr = 0; e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
            e_gid = '0; e_rsp = '0; e_rdata = '0;
            pend.delete();
        end else if (ce) begin
            foreach (pend[i]) pend[i].age++;
            e_rsp = '0;
            if (pend.size() > 0 && pend[0].age == 4) begin
                e_rsp[pend[0].id] = 1'b1;
                e_rdata = pend[0].data;
                void'(pend.pop_front());
            end
            if (g >= 0) begin
                a       = req_addr[g*ADDR_W +: ADDR_W];
                ptr     = (g + 1) % N_REQ;
                e_en    = 1'b1;
                e_we    = req_we[g];
                e_addr  = a;
                e_wdata = req_wdata[g*D_W +: D_W];
                e_gid   = 3'(g);
                if (req_we[g]) begin
                    ref_mem[int'(a)] = req_wdata[g*D_W +: D_W];
                end else begin
                    r.id = g; r.data = ref_read(a); r.age = 1;
                    pend.push_back(r);
                end
            end else begin
                e_en = 1'b0;
                e_we = 1'b0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [D_W-1:0] obs, input logic [D_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic cycle();
        int g;
        logic [N_REQ-1:0] er;
        @(negedge clk);
        g  = exp_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", D_W'(req_ready), D_W'(er));
        check("mem_en", D_W'(mem_en), D_W'(e_en));
        check("mem_we", D_W'(mem_we), D_W'(e_we));
        check("mem_addr", D_W'(mem_addr), D_W'(e_addr));
        check("mem_wdata", mem_wdata, e_wdata);
        check("grant_id", D_W'(grant_id), D_W'(e_gid));
        check("rsp_valid", D_W'(rsp_valid), D_W'(e_rsp));
        check("rsp_data", rsp_data, e_rdata);
        last_g = g;
        @(posedge clk);
        model_edge(g);
        #1;
    endtask

    task automatic set_req(input int id, input logic v, input logic we,
                           input logic [ADDR_W-1:0] a, input logic [D_W-1:0] d);
        req_valid[id]               = v;
        req_we[id]                  = we;
        req_addr[id*ADDR_W +: ADDR_W] = a;
        req_wdata[id*D_W +: D_W]      = d;
    endtask

    task automatic retire();
        if (last_g >= 0) req_valid[last_g] = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 1'b0, ADDR_W'(i), '0);

        // reset held with every requester valid, then release: grants 0..6 twice
        cycle(); cycle();
        rst = 1'b0;
        for (int n = 0; n < 14; n++) begin
            cycle();
            req_valid = '1;
        end
        idle(6);

        // write then read-after-write from a different requester
        set_req(4, 1'b1, 1'b1, 14'h0010, 64'h0000_0000_DEAD_BEEF);
        cycle(); retire();
        set_req(1, 1'b1, 1'b0, 14'h0010, '0);
        cycle(); retire();
        idle(6);

        // only id 6, then ids 6 and 0 continuously
        set_req(6, 1'b1, 1'b0, 14'h0003, '0);
        cycle(); cycle();
        set_req(0, 1'b1, 1'b0, 14'h0004, '0);
        for (int n = 0; n < 6; n++) cycle();
        idle(6);

        // two reads in flight across a 3-cycle ce stall
        set_req(2, 1'b1, 1'b0, 14'h0005, '0);
        set_req(3, 1'b1, 1'b0, 14'h0006, '0);
        cycle(); retire();
        cycle(); retire();
        ce = 1'b0;
        set_req(0, 1'b1, 1'b0, 14'h0001, '0);
        set_req(5, 1'b1, 1'b0, 14'h0002, '0);
        for (int n = 0; n < 3; n++) cycle();
        ce = 1'b1;
        for (int n = 0; n < 4; n++) begin cycle(); retire(); end
        idle(6);

        // reset one cycle after a read grant drops that response
        set_req(1, 1'b1, 1'b0, 14'h0007, '0);
        cycle(); retire();
        rst = 1'b1;
        set_req(2, 1'b1, 1'b0, 14'h0008, '0);
        cycle();
        rst = 1'b0;
        cycle(); retire();
        idle(8);

        // randomized traffic with ce stalls and occasional reset
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (last_g == i) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 99) < 40)
                    set_req(i, 1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)),
                            {$urandom, $urandom});
            end
            ce  = ($urandom_range(0, 99) < 85);
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0; ce = 1'b1;
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
